// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_pkg
// Description : Constants and types for the LEGv8 writeback stage. The load
//               opcodes and the zero-register number are also used by the
//               decode and control stages.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_stage_pkg;

  // instruction[31:21] encodings of the load family
  localparam logic [10:0] OP_LDUR   = 11'h7C2;
  localparam logic [10:0] OP_LDURB  = 11'h1C2;
  localparam logic [10:0] OP_LDURH  = 11'h3C2;
  localparam logic [10:0] OP_LDURSW = 11'h5C4;

  // XZR: writes to it are architecturally discarded
  localparam logic [4:0]  XZR       = 5'd31;

  // One buffered register write
  typedef struct packed {
    logic [4:0]  dest;
    logic [63:0] data;
  } wb_entry_t;

endpackage : writeback_stage_pkg
`default_nettype wire

// File: rtl/wb_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : wb_load_extend
// Description : Combinational load-data narrowing/extension selected by the
//               load opcode. Unknown opcodes pass the full doubleword.
// Ports       : op_code_i  [10:0] instruction[31:21]
//               mem_data_i [63:0] raw doubleword from data memory
//               data64_o   [63:0] extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module wb_load_extend
  import writeback_stage_pkg::*;
(
  input  logic [10:0] op_code_i,
  input  logic [63:0] mem_data_i,
  output logic [63:0] data64_o
);

  always_comb begin
    data64_o = mem_data_i;
    case (op_code_i)
      OP_LDURB:  data64_o = {56'd0, mem_data_i[7:0]};
      OP_LDURH:  data64_o = {48'd0, mem_data_i[15:0]};
      OP_LDURSW: data64_o = {{32{mem_data_i[31]}}, mem_data_i[31:0]};
      default:   data64_o = mem_data_i;
    endcase
  end

endmodule : wb_load_extend
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final LEGv8 pipeline stage. Accepts completed instructions
//               over valid/ready, selects ALU or extended load data, buffers
//               the result in a small FIFO and retires at most one register
//               write per cycle when the write port is granted.
// Ports       : clk, reset            clock / synchronous active-high reset
//               in_valid, in_ready    memory-stage handshake
//               in_op_code [10:0]     instruction[31:21]
//               in_dest_reg [4:0]     destination register
//               in_reg_write          instruction writes a register
//               in_mem_to_reg         1 = load data, 0 = ALU result
//               in_alu_result [63:0]  ALU result
//               in_mem_data [63:0]    raw load doubleword
//               wb_grant              register-file write port available
//               reg_write             write enable pulse (registered)
//               write_reg [4:0]       write address (registered)
//               write_data [63:0]     write data (registered)
//               retired_count [31:0]  writes issued since reset
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_op_code,
  input  logic [4:0]  in_dest_reg,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_mem_data,
  input  logic        wb_grant,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [63:0] write_data,
  output logic [31:0] retired_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // --------------------------------------------------------------------------
  // Result selection
  // --------------------------------------------------------------------------
  logic [63:0] load_data;
  wb_entry_t   new_entry;

  wb_load_extend u_load_extend (
    .op_code_i  (in_op_code),
    .mem_data_i (in_mem_data),
    .data64_o   (load_data)
  );

  always_comb begin
    new_entry.dest = in_dest_reg;
    new_entry.data = in_mem_to_reg ? load_data : in_alu_result;
  end

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  wb_entry_t       fifo_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic accept;
  logic push;
  logic pop;

  // Ready is based on the registered count only; a same-cycle pop never
  // opens a slot, which keeps ready off the grant path.
  assign in_ready = (count_q < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  // Non-writing instructions and XZR writes are consumed but never buffered.
  assign push     = accept && in_reg_write && (in_dest_reg != XZR);
  assign pop      = (count_q != '0) && wb_grant;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: entries are only ever read below count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  // --------------------------------------------------------------------------
  // Pointers, count and registered write-port outputs
  // --------------------------------------------------------------------------
  logic        reg_write_q;
  logic [4:0]  write_reg_q;
  logic [63:0] write_data_q;
  logic [31:0] retired_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      reg_write_q     <= 1'b0;
      write_reg_q     <= '0;
      write_data_q    <= '0;
      retired_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_write_q <= pop;
      if (pop) begin
        // Address/data hold their last values between retires.
        write_reg_q     <= fifo_q[rd_ptr_q].dest;
        write_data_q    <= fifo_q[rd_ptr_q].data;
        retired_count_q <= retired_count_q + 32'd1;
      end
    end
  end

  assign reg_write     = reg_write_q;
  assign write_reg     = write_reg_q;
  assign write_data    = write_data_q;
  assign retired_count = retired_count_q;

endmodule : writeback_stage
`default_nettype wire
